// File: rtl/jrb8_pkg.sv
// Shared definitions for the jrb8 datapath: ALU opcodes, flag bit positions and
// the range of opcodes that run on the iterative multiply/divide engine.
package jrb8_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ASR  = 4'hA,
        OP_CMP  = 4'hB,
        OP_MUL  = 4'hC,
        OP_MULH = 4'hD,
        OP_DIV  = 4'hE,
        OP_MOD  = 4'hF
    } alu_op_t;

    // Bit positions inside the {V,N,C,Z} flags vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam alu_op_t ALU_ITER_OP_FIRST = OP_MUL;
    localparam alu_op_t ALU_ITER_OP_LAST  = OP_MOD;

    function automatic logic is_iter_op(input alu_op_t op);
        return (op >= ALU_ITER_OP_FIRST) && (op <= ALU_ITER_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Shared iterative engine: shift-add multiplier and restoring divider, one bit per step.
// acc_hi/acc_lo present the accumulator value after the current edge, so the final step is usable directly.
module alu_iter
    import jrb8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_div,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem    = {hi_q, lo_q[WIDTH-1]};
        diff   = rem - {1'b0, opnd_q};
        if (start) begin
            // MUL: hi=partial product, lo=multiplier. DIV: hi=remainder, lo=dividend/quotient.
            hi_d   = '0;
            lo_d   = is_div ? a : b;
            opnd_d = is_div ? b : a;
            div_d  = is_div;
        end else if (step) begin
            if (div_q) begin
                hi_d = diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        opnd_q <= opnd_d;
        div_q  <= div_d;
    end

    assign acc_hi = hi_d;
    assign acc_lo = lo_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU behind the control unit: IDLE/BUSY handshake on alu_done, single-cycle
// logic/arithmetic ops plus WIDTH-cycle MUL/DIV through alu_iter, registered result and flags.
module alu_seq
    import jrb8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_executing,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             alu_done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;

    logic             start, busy, finish;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic signed [WIDTH-1:0] a_s, asr_s;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic c,
                                              input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_V] = v;
        return f;
    endfunction

    assign start  = (state_q == ST_IDLE) && alu_executing;
    assign busy   = (state_q == ST_BUSY);
    assign finish = busy && (cnt_q == CNT_W'(1));

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .start  (start),
        .step   (busy),
        .a      (a),
        .b      (b),
        .is_div ((op == OP_DIV) || (op == OP_MOD)),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    always_comb begin
        a_s     = a_q;
        asr_s   = a_s >>> 1;
        add_ext = {1'b0, a_q} + {1'b0, b_q}
                + {{WIDTH{1'b0}}, cin_q & (op_q == OP_ADC)};
        sub_ext = {1'b0, a_q} - {1'b0, b_q}
                - {{WIDTH{1'b0}}, ~cin_q & (op_q == OP_SBB)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = ~sub_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOT:  alu_res = ~a_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            OP_ASR: begin
                alu_res = asr_s;
                alu_c   = a_q[0];
            end
            OP_MUL: begin
                alu_res = acc_lo;
                alu_c   = |acc_hi;
                alu_v   = |acc_hi;
            end
            OP_MULH: alu_res = acc_hi;
            OP_DIV: begin
                alu_res = acc_lo;
                alu_v   = (b_q == '0);
            end
            OP_MOD: begin
                alu_res = acc_hi;
                alu_v   = (b_q == '0);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        if (start) begin
            state_d = ST_BUSY;
            done_d  = 1'b0;
            cnt_d   = is_iter_op(alu_op_t'(op)) ? CNT_W'(WIDTH) : CNT_W'(1);
            op_d    = alu_op_t'(op);
            a_d     = a;
            b_d     = b;
            cin_d   = carry_in;
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
            if (finish) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                flags_d = pack_flags(alu_res, alu_c, alu_v);
                if (op_q != OP_CMP) begin
                    result_d = alu_res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b1;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Operand latches carry no control meaning, so they stay out of the reset domain
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        b_q   <= b_d;
        cin_q <= cin_d;
    end

    assign alu_done = done_q;
    assign result   = result_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and CU-style random checks for alu_seq: reset, handshake latency, results and flags.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_executing;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       carry_in;
    logic       alu_done;
    logic [7:0] result;
    logic [3:0] flags;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_executing (alu_executing),
        .op            (op),
        .a             (a),
        .b             (b),
        .carry_in      (carry_in),
        .alu_done      (alu_done),
        .result        (result),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {result, V, N, C, Z}
    function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] x,
                                          input logic [7:0] y, input logic ci,
                                          input logic [7:0] prev);
        int ux, uy, sx, sy, t, s;
        logic [7:0] r, ro;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        r = 8'h00; c = 1'b0; v = 1'b0; t = 0; s = 0;
        case (o)
            4'h0, 4'h1: begin
                t = ux + uy + ((o == 4'h1) ? int'(ci) : 0);
                s = sx + sy + ((o == 4'h1) ? int'(ci) : 0);
                r = 8'(t); c = (t > 255); v = (s > 127) || (s < -128);
            end
            4'h2, 4'h3, 4'hB: begin
                t = ux - uy - ((o == 4'h3 && !ci) ? 1 : 0);
                s = sx - sy - ((o == 4'h3 && !ci) ? 1 : 0);
                r = 8'(t); c = (t >= 0); v = (s > 127) || (s < -128);
            end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = x ^ y;
            4'h7: r = ~x;
            4'h8: begin r = {x[6:0], 1'b0}; c = x[7]; end
            4'h9: begin r = {1'b0, x[7:1]}; c = x[0]; end
            4'hA: begin r = {x[7], x[7:1]}; c = x[0]; end
            4'hC: begin t = ux * uy; r = 8'(t); c = (t > 255); v = (t > 255); end
            4'hD: begin t = ux * uy; r = 8'(t >> 8); end
            4'hE: begin
                if (uy == 0) begin r = 8'hFF; v = 1'b1; end
                else r = 8'(ux / uy);
            end
            default: begin
                if (uy == 0) begin r = x; v = 1'b1; end
                else r = 8'(ux % uy);
            end
        endcase
        ro = (o == 4'hB) ? prev : r;
        return {ro, v, r[7], c, (r == 8'h00)};
    endfunction

    // CU-style request: executing held for the start cycle plus one extra cycle.
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic [7:0] exp_r, input logic [3:0] exp_f,
                          input int exp_lat, input logic hold_chk, input string tag);
        int lat;
        @(negedge clk);
        alu_executing = 1'b1;
        op = o; a = x; b = y; carry_in = ci;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 1) alu_executing = 1'b0;
            if (alu_done) begin
                alu_executing = 1'b0;
                break;
            end
            lat++;
        end
        alu_executing = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, {24'h0, result}, {24'h0, exp_r});
        check({tag, "_flags"}, {28'h0, flags}, {28'h0, exp_f});
        if (hold_chk) begin
            @(negedge clk);
            check({tag, "_idle"}, {31'h0, alu_done}, 32'h1);
        end
    endtask

    logic [11:0] exp_m;
    logic [7:0]  prev_r;
    logic [3:0]  r_op;
    logic [7:0]  r_a, r_b;
    logic        r_ci;
    int          gap;

    initial begin
        rst_n = 1'b0; alu_executing = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", {31'h0, alu_done}, 32'h1);
        check("rst_res", {24'h0, result}, 32'h0);
        check("rst_flags", {28'h0, flags}, 32'h0);
        rst_n = 1'b1;

        run_op(4'h6, 8'hF0, 8'h0F, 1'b0, 8'hFF, 4'h4, 1, 1'b1, "xor");

        // Reset in the middle of a MUL, four iterations in
        @(negedge clk);
        alu_executing = 1'b1; op = 4'hC; a = 8'h12; b = 8'h34;
        @(negedge clk);
        @(negedge clk);
        alu_executing = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy", {31'h0, alu_done}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_done", {31'h0, alu_done}, 32'h1);
        check("arst_res", {24'h0, result}, 32'h0);
        check("arst_flags", {28'h0, flags}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'hC, 1, 1'b1, "add");
        run_op(4'h2, 8'h05, 8'h05, 1'b0, 8'h00, 4'h3, 1, 1'b0, "sub");
        run_op(4'hB, 8'h03, 8'h09, 1'b0, 8'h00, 4'h4, 1, 1'b1, "cmp");
        run_op(4'h1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'h3, 1, 1'b1, "adc");
        run_op(4'h3, 8'h00, 8'h00, 1'b0, 8'hFF, 4'h4, 1, 1'b1, "sbb");
        run_op(4'h8, 8'h81, 8'h00, 1'b0, 8'h02, 4'h2, 1, 1'b1, "shl");
        run_op(4'h9, 8'h81, 8'h00, 1'b0, 8'h40, 4'h2, 1, 1'b1, "shr");
        run_op(4'hA, 8'h81, 8'h00, 1'b0, 8'hC0, 4'h6, 1, 1'b1, "asr");
        run_op(4'h7, 8'hFF, 8'h00, 1'b0, 8'h00, 4'h1, 1, 1'b1, "not");
        run_op(4'hC, 8'h12, 8'h34, 1'b0, 8'hA8, 4'hE, 8, 1'b1, "mul");
        run_op(4'hD, 8'h12, 8'h34, 1'b0, 8'h03, 4'h0, 8, 1'b1, "mulh");
        run_op(4'hE, 8'hC8, 8'h07, 1'b0, 8'h1C, 4'h0, 8, 1'b1, "div");
        run_op(4'hF, 8'hC8, 8'h07, 1'b0, 8'h04, 4'h0, 8, 1'b1, "mod");
        run_op(4'hE, 8'h42, 8'h00, 1'b0, 8'hFF, 4'hC, 8, 1'b1, "div0");
        run_op(4'hF, 8'h42, 8'h00, 1'b0, 8'h42, 4'h8, 8, 1'b1, "mod0");

        prev_r = 8'h42;
        for (int i = 0; i < 50; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = 8'($urandom_range(0, 255));
            r_b  = 8'($urandom_range(0, 255));
            r_ci = 1'($urandom_range(0, 1));
            if (i % 10 == 3) r_b = 8'h00;
            gap  = int'($urandom_range(0, 3));
            exp_m = model(r_op, r_a, r_b, r_ci, prev_r);
            run_op(r_op, r_a, r_b, r_ci, exp_m[11:4], exp_m[3:0], (r_op >= 4'hC) ? 8 : 1,
                   (gap > 0), $sformatf("rnd%0d_op%0h", i, r_op));
            prev_r = exp_m[11:4];
            if (gap > 1) repeat (gap - 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
